// File: rtl/out_port_alloc_pkg.sv
// Shared router constants, flit field layout and allocator types.
// Imported by the output-port allocator, its interface and the input ports.
package out_port_alloc_pkg;

    localparam int unsigned FLIT_SIZE   = 16;
    localparam int unsigned OUTPORT_CNT = 7;
    localparam int unsigned VC_SIZE     = 4;
    localparam int unsigned VC_W        = 2;
    localparam int unsigned BUF_DEPTH   = 4;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned PORT_W      = $clog2(OUTPORT_CNT);

    // Flit header layout: head and tail flags in the MSBs, then the target VC
    localparam int unsigned FLIT_HEAD_BIT = FLIT_SIZE - 1;
    localparam int unsigned FLIT_TAIL_BIT = FLIT_SIZE - 2;
    localparam int unsigned FLIT_VC_LSB   = FLIT_SIZE - 2 - VC_W;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } alloc_state_e;

    typedef struct packed {
        logic [FLIT_SIZE-1:0] flit;
        logic [VC_W-1:0]      vc;
    } link_flit_t;

    function automatic logic [PORT_W-1:0] wrap_inc(input logic [PORT_W-1:0] p);
        return (p == PORT_W'(OUTPORT_CNT - 1)) ? '0 : p + PORT_W'(1);
    endfunction

endpackage

// File: rtl/out_port_alloc_if.sv
// Request/grant and link signals between the input ports and one output allocator.
interface out_port_alloc_if;
    import out_port_alloc_pkg::*;

    logic [OUTPORT_CNT-1:0]           req;
    logic [OUTPORT_CNT-1:0]           req_head;
    logic [OUTPORT_CNT-1:0]           req_tail;
    logic [OUTPORT_CNT*VC_W-1:0]      req_vc;
    logic [OUTPORT_CNT*FLIT_SIZE-1:0] flit_in;
    logic [OUTPORT_CNT-1:0]           grant;
    logic [VC_SIZE-1:0]               credit_in;
    logic [FLIT_SIZE-1:0]             flit_out;
    logic                             flit_out_valid;
    logic [VC_W-1:0]                  flit_out_vc;
    logic [OUTPORT_CNT-1:0]           owner;
    logic                             credit_err;

    modport master (
        output req, req_head, req_tail, req_vc, flit_in, credit_in,
        input  grant, flit_out, flit_out_valid, flit_out_vc, owner, credit_err
    );

    modport slave (
        input  req, req_head, req_tail, req_vc, flit_in, credit_in,
        output grant, flit_out, flit_out_valid, flit_out_vc, owner, credit_err
    );

endinterface

// File: rtl/out_port_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i wins.
// Kept generic so VC allocation can reuse it.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + SUM_W'(k);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_alloc.sv
// Output-port switch allocator: round-robin with wormhole locking, per-VC
// downstream credit tracking and a registered link stage.
module out_port_alloc
    import out_port_alloc_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    out_port_alloc_if.slave port_if
);

    localparam int unsigned N_IN = OUTPORT_CNT;

    alloc_state_e         state_q, state_d;
    logic [N_IN-1:0]      owner_q, owner_d;
    logic [PORT_W-1:0]    owner_idx_q, owner_idx_d;
    logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]      lock_vc_q, lock_vc_d;
    logic [CNT_W-1:0]     credit_q [VC_SIZE];
    logic [CNT_W-1:0]     credit_d [VC_SIZE];
    logic                 credit_err_q, credit_err_d;
    link_flit_t           link_q, link_d;
    logic                 link_valid_q;

    logic [VC_W-1:0]      in_vc   [N_IN];
    logic [FLIT_SIZE-1:0] in_flit [N_IN];
    logic [N_IN-1:0]      eligible;
    logic [N_IN-1:0]      arb_gnt;
    logic [PORT_W-1:0]    arb_idx;
    logic [N_IN-1:0]      grant_c;
    logic [PORT_W-1:0]    send_idx;
    logic [VC_W-1:0]      send_vc;
    logic                 send;

    // Input 0 sits in the MSBs of the flattened buses
    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign in_vc[i]    = port_if.req_vc[(N_IN-1-i)*VC_W +: VC_W];
        assign in_flit[i]  = port_if.flit_in[(N_IN-1-i)*FLIT_SIZE +: FLIT_SIZE];
        assign eligible[i] = port_if.req[i] & port_if.req_head[i]
                           & (credit_q[in_vc[i]] != '0);
    end

    rr_arbiter #(.N(N_IN)) u_arb (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (arb_gnt[i]) arb_idx = PORT_W'(i);
        end
    end

    // Grant selection and lock / pointer bookkeeping
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_idx_d = owner_idx_q;
        rr_ptr_d    = rr_ptr_q;
        lock_vc_d   = lock_vc_q;
        grant_c     = '0;
        send_idx    = owner_idx_q;
        send_vc     = lock_vc_q;
        case (state_q)
            ST_IDLE: begin
                grant_c  = arb_gnt;
                send_idx = arb_idx;
                send_vc  = in_vc[arb_idx];
                if (|arb_gnt) begin
                    if (port_if.req_tail[arb_idx]) begin
                        rr_ptr_d = wrap_inc(arb_idx);
                    end else begin
                        state_d     = ST_LOCKED;
                        owner_d     = arb_gnt;
                        owner_idx_d = arb_idx;
                        lock_vc_d   = in_vc[arb_idx];
                    end
                end
            end
            ST_LOCKED: begin
                if (port_if.req[owner_idx_q] && (credit_q[lock_vc_q] != '0)) begin
                    grant_c = owner_q;
                    if (port_if.req_tail[owner_idx_q]) begin
                        state_d  = ST_IDLE;
                        owner_d  = '0;
                        rr_ptr_d = wrap_inc(owner_idx_q);
                    end
                end
            end
            default: ;
        endcase
        send = |grant_c;
    end

    // Simultaneous send and return cancel; a return at full depth saturates
    always_comb begin
        credit_err_d = credit_err_q;
        for (int unsigned v = 0; v < VC_SIZE; v++) begin
            credit_d[v] = credit_q[v];
            if (send && (send_vc == VC_W'(v)) && !port_if.credit_in[v]) begin
                credit_d[v] = credit_q[v] - CNT_W'(1);
            end else if (port_if.credit_in[v] && !(send && (send_vc == VC_W'(v)))) begin
                if (credit_q[v] == CNT_W'(BUF_DEPTH)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        link_d      = link_q;
        if (send) begin
            link_d.flit = in_flit[send_idx];
            link_d.vc   = send_vc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            owner_idx_q  <= '0;
            rr_ptr_q     <= '0;
            lock_vc_q    <= '0;
            credit_err_q <= 1'b0;
            link_q       <= '0;
            link_valid_q <= 1'b0;
            for (int unsigned v = 0; v < VC_SIZE; v++) begin
                credit_q[v] <= CNT_W'(BUF_DEPTH);
            end
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            owner_idx_q  <= owner_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_vc_q    <= lock_vc_d;
            credit_err_q <= credit_err_d;
            link_q       <= link_d;
            link_valid_q <= send;
            for (int unsigned v = 0; v < VC_SIZE; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign port_if.grant          = grant_c;
    assign port_if.flit_out       = link_q.flit;
    assign port_if.flit_out_valid = link_valid_q;
    assign port_if.flit_out_vc    = link_q.vc;
    assign port_if.owner          = owner_q;
    assign port_if.credit_err     = credit_err_q;

endmodule
